// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared types and constants for the EX-stage HI/LO producer.
package ex_hilo_muldiv_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DWORD_W  = 2 * WORD_W;
    localparam int unsigned DIV_ITER = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_ON  = 2'd1,
        ST_DIV_END = 2'd2
    } div_state_e;

    function automatic logic [WORD_W-1:0] neg_word(input logic [WORD_W-1:0] x);
        return ~x + WORD_W'(1);
    endfunction

    function automatic logic [WORD_W-1:0] abs_word(input logic [WORD_W-1:0] x);
        return x[WORD_W-1] ? neg_word(x) : x;
    endfunction

    function automatic logic is_div_op(input hilo_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_hilo_muldiv_if.sv
// Pipeline-side bundle of the HI/LO producer: op/operands in, HI/LO write data and stall out.
interface ex_hilo_muldiv_if;
    import ex_hilo_muldiv_pkg::*;

    logic              flush_i;
    hilo_op_e          op_i;
    logic [WORD_W-1:0] rs_i;
    logic [WORD_W-1:0] rt_i;
    logic [WORD_W-1:0] hi_i;
    logic [WORD_W-1:0] lo_i;
    logic [WORD_W-1:0] hi_o;
    logic [WORD_W-1:0] lo_o;
    logic              write_hilo_o;
    logic              stall_req_o;

    modport master (
        output flush_i, op_i, rs_i, rt_i, hi_i, lo_i,
        input  hi_o, lo_o, write_hilo_o, stall_req_o
    );

    modport slave (
        input  flush_i, op_i, rs_i, rt_i, hi_i, lo_i,
        output hi_o, lo_o, write_hilo_o, stall_req_o
    );

endinterface

// File: rtl/ex_hilo_muldiv_div_core_unsigned.sv
// Unsigned restoring divider: one shift/subtract per cycle for ITER cycles after start.
module ex_hilo_muldiv_div_core_unsigned
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int unsigned ITER = DIV_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    output logic [WORD_W-1:0] quotient,
    output logic [WORD_W-1:0] remainder,
    output logic              done_c
);

    localparam int unsigned CNT_W = $clog2(ITER);

    logic [WORD_W-1:0] rem_q;
    logic [WORD_W-1:0] quo_q;
    logic [WORD_W-1:0] dsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [WORD_W:0]   shifted;
    logic [WORD_W:0]   diff;

    // Trial subtraction of the divisor from the partial remainder shifted by one quotient bit.
    always_comb begin
        shifted = {rem_q, quo_q[WORD_W-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    assign done_c    = busy_q && (cnt_q == CNT_W'(ITER - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (!diff[WORD_W]) begin
                rem_q <= diff[WORD_W-1:0];
                quo_q <= {quo_q[WORD_W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WORD_W-1:0];
                quo_q <= {quo_q[WORD_W-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_hilo_muldiv.sv
// EX-stage HI/LO write-data producer: single-cycle MULT/MULTU/MTHI/MTLO, sequential DIV/DIVU with stall.
module ex_hilo_muldiv
    import ex_hilo_muldiv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ex_hilo_muldiv_if.slave      bus
);

    div_state_e        state_q;
    div_state_e        state_d;
    logic              q_neg_q;
    logic              r_neg_q;
    logic              by_zero_q;
    logic [WORD_W-1:0] zero_rem_q;

    logic              is_div;
    logic              signed_op;
    logic              rt_zero;
    logic              start_c;
    logic              core_done_c;
    logic [WORD_W-1:0] core_dividend;
    logic [WORD_W-1:0] core_divisor;
    logic [WORD_W-1:0] core_quo;
    logic [WORD_W-1:0] core_rem;
    logic [DWORD_W-1:0] prod_s;
    logic [DWORD_W-1:0] prod_u;

    logic [WORD_W-1:0] hi_c;
    logic [WORD_W-1:0] lo_c;
    logic              write_c;
    logic              stall_c;

    assign is_div        = is_div_op(bus.op_i);
    assign signed_op     = (bus.op_i == OP_DIV);
    assign rt_zero       = (bus.rt_i == ZERO_WORD);
    assign start_c       = (state_q == ST_IDLE) && is_div && !rt_zero && !bus.flush_i;
    assign core_dividend = signed_op ? abs_word(bus.rs_i) : bus.rs_i;
    assign core_divisor  = signed_op ? abs_word(bus.rt_i) : bus.rt_i;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign prod_s = {{WORD_W{bus.rs_i[WORD_W-1]}}, bus.rs_i} * {{WORD_W{bus.rt_i[WORD_W-1]}}, bus.rt_i};
    assign prod_u = {ZERO_WORD, bus.rs_i} * {ZERO_WORD, bus.rt_i};

    ex_hilo_muldiv_div_core_unsigned #(.ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start_c),
        .abort     (bus.flush_i),
        .dividend  (core_dividend),
        .divisor   (core_divisor),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done_c    (core_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (is_div) state_d = rt_zero ? ST_DIV_END : ST_DIV_ON;
            ST_DIV_ON:  if (core_done_c) state_d = ST_DIV_END;
            ST_DIV_END: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Result signs and the divide-by-zero remainder are captured once, when a divide is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            by_zero_q  <= 1'b0;
            zero_rem_q <= '0;
        end else if ((state_q == ST_IDLE) && is_div && !bus.flush_i) begin
            q_neg_q    <= signed_op && (bus.rs_i[WORD_W-1] ^ bus.rt_i[WORD_W-1]);
            r_neg_q    <= signed_op && bus.rs_i[WORD_W-1];
            by_zero_q  <= rt_zero;
            zero_rem_q <= bus.rs_i;
        end
    end

    always_comb begin
        hi_c    = ZERO_WORD;
        lo_c    = ZERO_WORD;
        write_c = 1'b0;
        stall_c = 1'b0;
        if (state_q == ST_DIV_END) begin
            write_c = 1'b1;
            if (by_zero_q) begin
                lo_c = '1;
                hi_c = zero_rem_q;
            end else begin
                lo_c = q_neg_q ? neg_word(core_quo) : core_quo;
                hi_c = r_neg_q ? neg_word(core_rem) : core_rem;
            end
        end else begin
            case (bus.op_i)
                OP_MULT:  begin {hi_c, lo_c} = prod_s; write_c = 1'b1; end
                OP_MULTU: begin {hi_c, lo_c} = prod_u; write_c = 1'b1; end
                OP_MTHI:  begin hi_c = bus.rs_i; lo_c = bus.lo_i; write_c = 1'b1; end
                OP_MTLO:  begin hi_c = bus.hi_i; lo_c = bus.rs_i; write_c = 1'b1; end
                OP_DIV, OP_DIVU: stall_c = 1'b1;
                default: ;
            endcase
        end
        // Flush and reset both silence every output in the same cycle.
        if (bus.flush_i || rst) begin
            hi_c    = ZERO_WORD;
            lo_c    = ZERO_WORD;
            write_c = 1'b0;
            stall_c = 1'b0;
        end
    end

    assign bus.hi_o         = hi_c;
    assign bus.lo_o         = lo_c;
    assign bus.write_hilo_o = write_c;
    assign bus.stall_req_o  = stall_c;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Self-checking bench for ex_hilo_muldiv against an arithmetic reference model.
module tb_ex_hilo_muldiv;
    import ex_hilo_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ex_hilo_muldiv_if bus();

    ex_hilo_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference division: quotient truncates toward zero, remainder follows the dividend.
    function automatic void div_model(input hilo_op_e op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.op_i = OP_MULT;
        bus.rs_i = 32'hFFFF_FFFE;
        bus.rt_i = 32'd3;
        bus.hi_i = 32'h1111_1111;
        bus.lo_i = 32'h2222_2222;
        #3;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs got hi=%h lo=%h w=%b s=%b want all 0",
                     bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o);
        end
        next_cycle();
        rst = 1'b0;
        bus.op_i = OP_NONE;
        #3;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o} !== 66'd0) begin
            errors++;
            $display("FAIL idle_none got hi=%h lo=%h w=%b s=%b want all 0",
                     bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o);
        end
    endtask

    task automatic test_mult();
        logic [31:0] a;
        logic [31:0] b;
        hilo_op_e    op;
        longint      sa;
        longint      sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            if (i < 2) begin
                a = 32'hFFFF_FFFE; b = 32'd3; op = (i == 0) ? OP_MULT : OP_MULTU;
            end else if (i < 4) begin
                a = 32'h8000_0000; b = 32'h8000_0000; op = (i == 2) ? OP_MULT : OP_MULTU;
            end else begin
                a = $urandom; b = $urandom; op = $urandom_range(0, 1) ? OP_MULT : OP_MULTU;
            end
            sa = $signed(a); sb = $signed(b);
            ua = a; ub = b;
            exp = (op == OP_MULT) ? 64'(sa * sb) : 64'(ua * ub);
            next_cycle();
            bus.op_i = op; bus.rs_i = a; bus.rt_i = b;
            #3;
            checks++;
            if ({bus.hi_o, bus.lo_o} !== exp || bus.write_hilo_o !== 1'b1 || bus.stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL mult[%0d] op=%0d a=%h b=%h got %h_%h w=%b s=%b want %h w=1 s=0",
                         i, op, a, b, bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o, exp);
            end
        end
        next_cycle();
        bus.op_i = OP_NONE;
    endtask

    task automatic test_move();
        logic [31:0] a;
        logic [31:0] hin;
        logic [31:0] lin;
        hilo_op_e    op;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                a = 32'h1234_5678; hin = $urandom; lin = 32'hCAFE_F00D; op = OP_MTHI;
            end else begin
                a = $urandom; hin = $urandom; lin = $urandom;
                op = $urandom_range(0, 1) ? OP_MTHI : OP_MTLO;
            end
            exp_hi = (op == OP_MTHI) ? a : hin;
            exp_lo = (op == OP_MTLO) ? a : lin;
            next_cycle();
            bus.op_i = op; bus.rs_i = a; bus.rt_i = $urandom; bus.hi_i = hin; bus.lo_i = lin;
            #3;
            checks++;
            if (bus.hi_o !== exp_hi || bus.lo_o !== exp_lo || bus.write_hilo_o !== 1'b1 || bus.stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL move[%0d] op=%0d got hi=%h lo=%h w=%b s=%b want hi=%h lo=%h w=1 s=0",
                         i, op, bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o, exp_hi, exp_lo);
            end
        end
        next_cycle();
        bus.op_i = OP_NONE;
    endtask

    // Divides issued back to back; operands are scrambled after C0 to prove they are latched.
    task automatic test_div();
        hilo_op_e    ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        ops[0] = OP_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2;
        ops[1] = OP_DIVU; as[1] = 32'd100;       bs[1] = 32'd7;
        ops[2] = OP_DIV;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF;
        ops[3] = OP_DIV;  as[3] = 32'h0000_1234; bs[3] = 32'd0;
        ops[4] = OP_DIVU; as[4] = 32'hFFFF_FFFF; bs[4] = 32'hFFFF_FFFF;
        for (int k = 5; k < 12; k++) begin
            ops[k] = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
            as[k]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 1000);
            bs[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 :
                     ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 50));
        end
        for (int k = 0; k < 12; k++) begin
            div_model(ops[k], as[k], bs[k], eq, er);
            lat = (bs[k] == 32'd0) ? 1 : 33;
            next_cycle();
            bus.op_i = ops[k]; bus.rs_i = as[k]; bus.rt_i = bs[k];
            bus.hi_i = $urandom; bus.lo_i = $urandom;
            #3;
            for (int n = 0; n <= lat; n++) begin
                if (n > 0) begin
                    next_cycle();
                    bus.rs_i = $urandom; bus.rt_i = $urandom;
                    #3;
                end
                checks++;
                if (n < lat) begin
                    if (bus.stall_req_o !== 1'b1 || bus.write_hilo_o !== 1'b0) begin
                        errors++;
                        $display("FAIL div[%0d] C%0d got s=%b w=%b want s=1 w=0",
                                 k, n, bus.stall_req_o, bus.write_hilo_o);
                    end
                end else if (bus.write_hilo_o !== 1'b1 || bus.stall_req_o !== 1'b0 ||
                             bus.lo_o !== eq || bus.hi_o !== er) begin
                    errors++;
                    $display("FAIL div[%0d] C%0d op=%0d a=%h b=%h got lo=%h hi=%h w=%b s=%b want lo=%h hi=%h w=1 s=0",
                             k, n, ops[k], as[k], bs[k], bus.lo_o, bus.hi_o,
                             bus.write_hilo_o, bus.stall_req_o, eq, er);
                end
            end
        end
        next_cycle();
        bus.op_i = OP_NONE;
        #3;
        checks++;
        if (bus.write_hilo_o !== 1'b0 || bus.stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL div_after got w=%b s=%b want w=0 s=0", bus.write_hilo_o, bus.stall_req_o);
        end
    endtask

    task automatic test_flush();
        next_cycle();
        bus.op_i = OP_DIVU; bus.rs_i = 32'd1000; bus.rt_i = 32'd3;
        #3;
        for (int n = 0; n <= 10; n++) begin
            if (n > 0) begin
                next_cycle();
                if (n == 10) bus.flush_i = 1'b1;
                #3;
            end
            checks++;
            if (n < 10 && (bus.stall_req_o !== 1'b1 || bus.write_hilo_o !== 1'b0)) begin
                errors++;
                $display("FAIL flush_pre C%0d got s=%b w=%b want s=1 w=0", n, bus.stall_req_o, bus.write_hilo_o);
            end else if (n == 10 && (bus.stall_req_o !== 1'b0 || bus.write_hilo_o !== 1'b0)) begin
                errors++;
                $display("FAIL flush_cycle got s=%b w=%b want s=0 w=0", bus.stall_req_o, bus.write_hilo_o);
            end
        end
        next_cycle();
        bus.flush_i = 1'b0;
        bus.op_i = OP_NONE;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) next_cycle();
            #3;
            checks++;
            if (bus.write_hilo_o !== 1'b0 || bus.stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_post[%0d] got w=%b s=%b want w=0 s=0", n, bus.write_hilo_o, bus.stall_req_o);
            end
        end
        next_cycle();
        bus.op_i = OP_DIVU; bus.rs_i = 32'd9; bus.rt_i = 32'd3;
        #3;
        for (int n = 0; n <= 33; n++) begin
            if (n > 0) begin
                next_cycle();
                #3;
            end
            checks++;
            if (n < 33 && (bus.stall_req_o !== 1'b1 || bus.write_hilo_o !== 1'b0)) begin
                errors++;
                $display("FAIL refill C%0d got s=%b w=%b want s=1 w=0", n, bus.stall_req_o, bus.write_hilo_o);
            end else if (n == 33 && (bus.lo_o !== 32'd3 || bus.hi_o !== 32'd0 ||
                                     bus.write_hilo_o !== 1'b1 || bus.stall_req_o !== 1'b0)) begin
                errors++;
                $display("FAIL refill_result got lo=%h hi=%h w=%b s=%b want lo=3 hi=0 w=1 s=0",
                         bus.lo_o, bus.hi_o, bus.write_hilo_o, bus.stall_req_o);
            end
        end
        next_cycle();
        bus.op_i = OP_NONE;
    endtask

    task automatic test_async_reset();
        next_cycle();
        bus.op_i = OP_DIV; bus.rs_i = 32'hFFFF_0000; bus.rt_i = 32'd5;
        #3;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) begin
                next_cycle();
                #3;
            end
            checks++;
            if (bus.stall_req_o !== 1'b1) begin
                errors++;
                $display("FAIL areset_pre C%0d got s=%b want 1", n, bus.stall_req_o);
            end
        end
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o} !== 66'd0) begin
            errors++;
            $display("FAIL areset_now got hi=%h lo=%h w=%b s=%b want all 0",
                     bus.hi_o, bus.lo_o, bus.write_hilo_o, bus.stall_req_o);
        end
        next_cycle();
        bus.op_i = OP_NONE;
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) next_cycle();
            #3;
            checks++;
            if (bus.write_hilo_o !== 1'b0 || bus.stall_req_o !== 1'b0) begin
                errors++;
                $display("FAIL areset_post[%0d] got w=%b s=%b want w=0 s=0", n, bus.write_hilo_o, bus.stall_req_o);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_move();
        test_div();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/ex_hilo_muldiv.md
Name: ex_hilo_muldiv

Overview:
- EX-stage producer of HI/LO write data. It is the writer end of the HI/LO path whose forwarding mux consumes mem/wb write_hilo/hi/lo.
- Executes MULT/MULTU and MTHI/MTLO in one cycle, and DIV/DIVU on a 32-iteration sequential divider.
- Stalls the pipeline while a divide is in flight.
- Its hi_o/lo_o/write_hilo_o travel down EX/MEM/WB alongside the instruction.

Parameters:
DIV_ITER, 32, number of radix-2 divide iterations; equals operand width, not intended to change.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_i  in  1  exception/branch flush; aborts any in-flight divide
op_i  in  3  HI/LO op code (package enum); held stable by pipeline while stall_req_o=1
rs_i  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
rt_i  in  32  operand B (divisor / multiplier)
hi_i  in  32  current forwarded HI value
lo_i  in  32  current forwarded LO value
hi_o  out  32  HI write data
lo_o  out  32  LO write data
write_hilo_o  out  1  HI/LO write enable for this EX instruction
stall_req_o  out  1  request to freeze PC..EX

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, divider registers=0. All outputs are 0 during reset.
- op NONE: write_hilo_o=0, hi_o=0, lo_o=0, stall_req_o=0.
- MULT: {hi_o,lo_o} = signed 64-bit product of rs_i and rt_i. Combinational, same cycle. write_hilo_o=1, no stall.
- MULTU: same as MULT, unsigned.
- MTHI: hi_o=rs_i, lo_o=lo_i, write_hilo_o=1.
- MTLO: lo_o=rs_i, hi_o=hi_i, write_hilo_o=1.
- DIV/DIVU FSM, states IDLE, DIV_ON, DIV_END:
  - IDLE:
    - On a div op with rt_i!=0: latch |rs|, |rt| (signed) or raw operands (unsigned), plus the quotient sign and remainder sign. Go to DIV_ON, counter=0.
    - On a div op with rt_i==0: go directly to DIV_END with q=32'hFFFFFFFF, r=rs_i.
  - stall_req_o=1 combinationally whenever op_i is a div op and state is IDLE or DIV_ON.
  - DIV_ON: one restoring shift/subtract per cycle. After DIV_ITER cycles (counter reaches 31), go to DIV_END.
  - DIV_END:
    - stall_req_o=0, write_hilo_o=1.
    - lo_o = quotient, negated if signs differ (DIV only).
    - hi_o = remainder, taking the dividend's sign (DIV only).
    - Next cycle: IDLE unconditionally.
  - While in IDLE/DIV_ON with a div op: write_hilo_o=0.
- Latency:
  - Divide with nonzero divisor: start cycle is C0. Stall is asserted C0..C32 (33 cycles). The write pulse occurs in C33.
  - Divide by zero: stall in C0, write in C1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- flush_i=1 in any state: next state IDLE, result discarded. In the same cycle, write_hilo_o=0 and stall_req_o=0 (flush wins).
- Async reset mid-divide: immediate IDLE. No spurious write after release.
- Operands are sampled only on the IDLE->DIV_ON transition. Later changes to rs_i/rt_i are ignored.

Decomposition:
- Shared package:
  - hilo op enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - FSM state encoding.
  - Constants ZERO_WORD and DIV_ITER.
- One sub-module, div_core_unsigned:
  - Unsigned restoring 32-cycle divider with start/abort/done.
  - Sign pre/post-processing and the div-by-zero shortcut stay in ex_hilo_muldiv.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3 -> same cycle hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, write_hilo_o=1, stall_req_o=0. MULTU with the same operands -> hi_o=0x00000002, lo_o=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> stall_req_o=1 for C0..C32. In C33: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, write_hilo_o=1 for exactly one cycle. Then IDLE.
- DIVU rs=100, rt=7 -> C33: lo_o=0x0000000E, hi_o=0x00000002. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIV rs=0x1234, rt=0 -> stall only in C0. In C1: lo_o=0xFFFFFFFF, hi_o=0x00001234, write_hilo_o=1.
- DIVU started, flush_i=1 at C10 -> C10 stall_req_o=0 and write_hilo_o=0. No write afterwards. A following DIVU 9/3 completes normally: lo=3, hi=0.
- MTHI rs=0x12345678 with lo_i=0xCAFEF00D -> hi_o=0x12345678, lo_o=0xCAFEF00D, write=1. Separately, rst asserted at C5 of a divide -> outputs 0 immediately; after release with op NONE, no write and no stall.
